clk_en_gen_multi: RTL and testbench

CLK_EN_GEN_MULTI -- requirements
Module: clk_en_gen_multi

---
 rtl/clk_en_gen_multi.sv | 190 +++++++++++++++++++
 tb/tb_clk_en_gen_multi.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen_multi.sv
// rtl/clk_en_gen_multi.sv - multi-channel clock-enable / divided-clock generator gated by PLL lock
module clk_en_gen_multi #(
    parameter int  NUM_CH      = 2,
    parameter int  CNT_W       = 16,
    parameter int  DEF_DIV     = 1,
    parameter int  LOCK_CYCLES = 256,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              sync_all,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] div_clk,
    output logic              locked
);

    localparam int               SET_W       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST    = SET_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEF_DIV_EFF = (DEF_DIV < 1) ? CNT_W'(1) : CNT_W'(DEF_DIV);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Reset release is retimed so the block stays quiet for the first edges after reset_n rises
    logic [1:0] r_rst_sync;
    logic       w_rst_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_done = r_rst_sync[1];

    logic r_lk_meta;
    logic r_lk_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
        end else if (!w_rst_done) begin
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk_s    <= r_lk_meta;
        end
    end

    state_t           r_state;
    logic [SET_W-1:0] r_settle_cnt;
    logic             r_locked;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_WAIT;
            r_settle_cnt <= '0;
            r_locked     <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_lk_s) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!r_lk_s) begin
                        r_state <= ST_WAIT;
                    end else if (r_settle_cnt == SET_LAST) begin
                        r_state  <= ST_RUN;
                        r_locked <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!r_lk_s) begin
                        r_state  <= ST_WAIT;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_WAIT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign locked = r_locked;

    logic             w_run_entry;
    logic             w_run_stay;
    logic             w_realign_all;
    logic             w_cfg_ok;
    logic [CNT_W-1:0] w_wr_div;

    assign w_run_entry   = (r_state == ST_SETTLE) && r_lk_s && (r_settle_cnt == SET_LAST);
    assign w_run_stay    = (r_state == ST_RUN) && r_lk_s;
    assign w_realign_all = w_run_stay && sync_all;
    assign w_cfg_ok      = cfg_wr && w_rst_done && (32'(cfg_ch) < NUM_CH);
    assign w_wr_div      = (cfg_div == '0) ? CNT_W'(1) : cfg_div;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_phase;
        logic [CNT_W-1:0] r_pend_div;
        logic             r_pend_vld;
        logic [CNT_W-1:0] r_cnt;
        logic             r_ce;
        logic             r_div_clk;

        logic             w_wr;
        logic             w_wrap;
        logic [CNT_W-1:0] w_div_tgt;
        logic [CNT_W-1:0] w_phase_tgt;
        logic [CNT_W-1:0] w_load_cnt;
        logic [CNT_W-1:0] w_div_nxt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_active;

        assign w_wr        = w_cfg_ok && (cfg_ch == CH_W'(gi));
        assign w_wrap      = (r_cnt >= r_div - 1'b1);
        // A write landing on a realign edge wins over any older pending divide
        assign w_div_tgt   = w_wr ? w_wr_div : (r_pend_vld ? r_pend_div : r_div);
        assign w_phase_tgt = w_wr ? cfg_phase : r_phase;
        assign w_load_cnt  = (w_phase_tgt >= w_div_tgt) ? (w_div_tgt - 1'b1) : w_phase_tgt;

        always_comb begin
            w_div_nxt = r_div;
            w_cnt_nxt = '0;
            w_active  = 1'b0;
            if (w_run_entry || w_realign_all) begin
                w_div_nxt = w_div_tgt;
                w_cnt_nxt = w_load_cnt;
                w_active  = 1'b1;
            end else if (w_run_stay && w_wrap) begin
                w_div_nxt = r_pend_vld ? r_pend_div : r_div;
                w_active  = 1'b1;
            end else if (w_run_stay) begin
                w_cnt_nxt = r_cnt + 1'b1;
                w_active  = 1'b1;
            end else if (w_wr) begin
                w_div_nxt = w_wr_div;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_div      <= DEF_DIV_EFF;
                r_phase    <= '0;
                r_pend_div <= '0;
                r_pend_vld <= 1'b0;
                r_cnt      <= '0;
                r_ce       <= 1'b0;
                r_div_clk  <= 1'b0;
            end else begin
                r_div     <= w_div_nxt;
                r_cnt     <= w_cnt_nxt;
                r_ce      <= w_active && (w_cnt_nxt == w_div_nxt - 1'b1);
                r_div_clk <= w_active && (w_cnt_nxt < (w_div_nxt >> 1));
                if (w_wr) r_phase <= cfg_phase;
                if (w_run_entry || w_realign_all || (w_wr && !w_run_stay)) begin
                    r_pend_vld <= 1'b0;
                end else if (w_run_stay && w_wrap) begin
                    // A write on the wrap edge itself waits for the following wrap
                    r_pend_vld <= w_wr;
                    if (w_wr) r_pend_div <= w_wr_div;
                end else if (w_wr) begin
                    r_pend_vld <= 1'b1;
                    r_pend_div <= w_wr_div;
                end
            end
        end

        assign ce[gi]      = r_ce;
        assign div_clk[gi] = r_div_clk;
    end

endmodule

// File: tb/tb_clk_en_gen_multi.sv
// tb/tb_clk_en_gen_multi.sv - self-checking bench for clk_en_gen_multi
module tb_clk_en_gen_multi;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int LCK  = 4;
    localparam int DEFD = 1;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           pll_locked;
    logic           sync_all;
    logic           cfg_wr;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [CW-1:0]  cfg_phase;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] div_clk;
    logic           locked;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clk_en_gen_multi #(
        .NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEFD), .LOCK_CYCLES(LCK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .sync_all(sync_all),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .ce(ce), .div_clk(div_clk), .locked(locked)
    );

    typedef struct {
        int         div;
        int         phase;
        logic [7:0] ce_pat;
        logic [7:0] dclk_pat;
    } vec_t;

    vec_t vecs[7];

    // Reference model: lock = last LCK+1 synchronised samples all high; channels track position in period
    int             m_div[NCH];
    int             m_ph[NCH];
    int             m_pend[NCH];
    bit             m_pv[NCH];
    int             m_pos[NCH];
    bit             m_lock;
    bit             hist[$];
    logic [NCH-1:0] e_ce;
    logic [NCH-1:0] e_dclk;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = DEFD;
            m_ph[i]  = 0;
            m_pend[i] = 0;
            m_pv[i]  = 1'b0;
            m_pos[i] = 0;
        end
        m_lock = 1'b0;
        hist.delete();
        e_ce   = '0;
        e_dclk = '0;
    endtask

    task automatic model_edge();
        bit old_lock;
        bit hit;
        int wdiv;
        old_lock = m_lock;
        hist.push_back(pll_locked);
        m_lock = 1'b0;
        if (hist.size() >= LCK + 3) begin
            m_lock = 1'b1;
            for (int k = 0; k <= LCK; k++)
                if (!hist[hist.size() - 3 - k]) m_lock = 1'b0;
        end
        if (hist.size() > 32) void'(hist.pop_front());
        wdiv = (cfg_div == 0) ? 1 : int'(cfg_div);
        for (int i = 0; i < NCH; i++) begin
            hit = cfg_wr && (int'(cfg_ch) == i);
            if (!m_lock) begin
                if (hit) begin m_div[i] = wdiv; m_ph[i] = int'(cfg_phase); m_pv[i] = 1'b0; end
                m_pos[i] = 0;
            end else if (!old_lock || sync_all) begin
                if (hit) begin m_div[i] = wdiv; m_ph[i] = int'(cfg_phase); m_pv[i] = 1'b0; end
                else if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 1'b0; end
                m_pos[i] = (m_ph[i] < m_div[i] - 1) ? m_ph[i] : m_div[i] - 1;
            end else if (m_pos[i] == m_div[i] - 1) begin
                if (m_pv[i]) m_div[i] = m_pend[i];
                m_pv[i] = hit;
                if (hit) begin m_pend[i] = wdiv; m_ph[i] = int'(cfg_phase); end
                m_pos[i] = 0;
            end else begin
                m_pos[i]++;
                if (hit) begin m_pend[i] = wdiv; m_pv[i] = 1'b1; m_ph[i] = int'(cfg_phase); end
            end
            e_ce[i]   = m_lock && (m_pos[i] == m_div[i] - 1);
            e_dclk[i] = m_lock && (m_pos[i] < m_div[i] / 2);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", 32'({ce, div_clk, locked}), 32'({e_ce, e_dclk, m_lock}));
    endtask

    task automatic write_cfg(input int ch, input int d, input int p);
        cfg_wr    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = CW'(d);
        cfg_phase = CW'(p);
    endtask

    task automatic unlock();
        pll_locked = 1'b0;
        repeat (4) tick();
    endtask

    task automatic relock_check();
        pll_locked = 1'b1;
        for (int e = 1; e <= LCK + 3; e++) begin
            tick();
            check($sformatf("lock_edge%0d", e), 32'(locked), (e == LCK + 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [15:0] ce0_exp;
        logic [15:0] dclk0_exp;
        logic [7:0]  ce1_exp;
        int          drop;

        reset_n = 1'b0; pll_locked = 1'b0; sync_all = 1'b0;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
        vecs[0] = '{4, 0, 8'b00010001, 8'b11001100};
        vecs[1] = '{4, 2, 8'b01000100, 8'b00110011};
        vecs[2] = '{1, 5, 8'b11111111, 8'b00000000};
        vecs[3] = '{0, 0, 8'b11111111, 8'b00000000};
        vecs[4] = '{3, 7, 8'b10010010, 8'b01001001};
        vecs[5] = '{2, 1, 8'b10101010, 8'b01010101};
        vecs[6] = '{5, 0, 8'b00001000, 8'b11000110};
        model_reset();

        #1;
        check("reset_ce", 32'(ce), 32'd0);
        check("reset_dclk", 32'(div_clk), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("release_edge_quiet", 32'({ce, div_clk, locked}), 32'd0);
        tick(); tick();

        foreach (vecs[v]) begin
            unlock();
            write_cfg(0, vecs[v].div, vecs[v].phase);
            tick();
            cfg_wr = 1'b0;
            relock_check();
            for (int c = 0; c < 8; c++) begin
                check($sformatf("vec%0d_ce0_c%0d", v, c), 32'(ce[0]), 32'(vecs[v].ce_pat[7-c]));
                check($sformatf("vec%0d_dclk0_c%0d", v, c), 32'(div_clk[0]), 32'(vecs[v].dclk_pat[7-c]));
                tick();
            end
        end

        // Two-channel phase lead, then a mid-period divide change and an out-of-range write
        unlock();
        write_cfg(0, 4, 0); tick();
        write_cfg(1, 4, 2); tick();
        cfg_wr = 1'b0;
        relock_check();
        ce0_exp   = 16'b0001000001000001;
        dclk0_exp = 16'b1100111000111000;
        ce1_exp   = 8'b01000100;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("div_change_ce0_c%0d", c), 32'(ce[0]), 32'(ce0_exp[15-c]));
            check($sformatf("div_change_dclk0_c%0d", c), 32'(div_clk[0]), 32'(dclk0_exp[15-c]));
            if (c < 8) check($sformatf("lead_ce1_c%0d", c), 32'(ce[1]), 32'(ce1_exp[7-c]));
            cfg_wr = 1'b0;
            if (c == 1) write_cfg(0, 6, 0);
            if (c == 2) write_cfg(3, 2, 0);
            tick();
        end
        cfg_wr = 1'b0;

        pll_locked = 1'b0;
        tick(); check("unlock_e1_locked", 32'(locked), 32'd1);
        tick(); check("unlock_e2_locked", 32'(locked), 32'd1);
        tick();
        check("unlock_e3_locked", 32'(locked), 32'd0);
        check("unlock_e3_ce", 32'(ce), 32'd0);
        check("unlock_e3_dclk", 32'(div_clk), 32'd0);
        relock_check();
        for (int c = 0; c < 6; c++) begin
            check($sformatf("relock_ce0_c%0d", c), 32'(ce[0]), (c == 5) ? 32'd1 : 32'd0);
            check($sformatf("relock_dclk0_c%0d", c), 32'(div_clk[0]), (c < 3) ? 32'd1 : 32'd0);
            tick();
        end

        #2 reset_n = 1'b0;
        #1;
        check("async_reset_ce", 32'(ce), 32'd0);
        check("async_reset_dclk", 32'(div_clk), 32'd0);
        check("async_reset_locked", 32'(locked), 32'd0);
        model_reset();
        pll_locked = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        relock_check();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("def_div_ce_c%0d", c), 32'(ce), 32'(3'b111));
            check($sformatf("def_div_dclk_c%0d", c), 32'(div_clk), 32'd0);
            tick();
        end

        drop = 0;
        for (int n = 0; n < 3000; n++) begin
            if (drop > 0) begin
                pll_locked = 1'b0;
                drop--;
            end else begin
                pll_locked = 1'b1;
                if ($urandom_range(0, 299) == 0) drop = int'($urandom_range(1, 12));
            end
            cfg_wr    = ($urandom_range(0, 5) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = CW'($urandom_range(0, 7));
            cfg_phase = CW'($urandom_range(0, 8));
            sync_all  = ($urandom_range(0, 19) == 0);
            tick();
        end
        cfg_wr = 1'b0; sync_all = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
